// File: rtl/vram_port_pkg.sv
// rtl/vram_port_pkg.sv - shared types for the CPU VRAM port queue
// Purpose: queue entry format, entry kinds and sequencer FSM states.
// Ports: none (package).
package vram_port_pkg;

  localparam int unsigned PAYLOAD_W = 19;

  typedef enum logic [1:0] {
    KIND_WR     = 2'd0,
    KIND_ADDR_W = 2'd1,
    KIND_ADDR_R = 2'd2,
    KIND_RD     = 2'd3
  } entry_kind_t;

  typedef struct packed {
    entry_kind_t            kind;
    logic [PAYLOAD_W-1:0]   payload;
  } vram_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_WR,
    ST_WAIT_ADDR,
    ST_WAIT_RD
  } state_t;

  function automatic vram_entry_t make_entry(entry_kind_t kind, logic [PAYLOAD_W-1:0] payload);
    vram_entry_t e;
    e.kind    = kind;
    e.payload = payload;
    return e;
  endfunction

endpackage

// File: rtl/vram_port_fifo.sv
// rtl/vram_port_fifo.sv - synchronous FIFO of vram_entry_t
// Purpose: holds CPU VRAM requests in arrival order.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   push_i/push_data_i  enqueue; ignored when full unless popping in the same cycle
//   pop_i           dequeue head; ignored when empty
//   head_o          current head entry (valid when !empty_o)
//   full_o/empty_o  occupancy flags, derived from registered count
module vram_port_fifo
  import vram_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  vram_entry_t push_data_i,
  input  logic        pop_i,
  output vram_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  vram_entry_t   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_en, pop_en;

  assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_en  = pop_i && !empty_o;
  // A pop frees a slot in the same edge, so a full FIFO may still accept.
  assign push_en = push_i && (!full_o || pop_en);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vram_cpu_port_queue.sv
// rtl/vram_cpu_port_queue.sv - CPU VRAM request queue and toggle-handshake sequencer
// Purpose: buffers CPU writes, address sets and read-ahead requests and issues
//   them in order to the VRAM arbiter; holds the read-ahead byte for port #0.
// Ports:
//   CLK21M, RESET                clock, asynchronous active-high reset
//   cpu_wr_stb/cpu_wr_data       CPU VRAM write
//   cpu_rd_stb                   CPU consumed read-ahead byte
//   cpu_addr_stb/cpu_addr/cpu_addr_read  CPU address set
//   VDPVRAM*ACK                  arbiter ack toggles
//   vram_rd_valid/vram_rd_data   read byte from arbiter
//   VDPVRAM*REQ                  request toggles
//   VDPVRAMACCESSDATA/ADDRTMP    payload for the outstanding request
//   cpu_rd_data                  read-ahead byte
//   queue_full, busy, overflow   status (overflow is sticky until reset)
module vram_cpu_port_queue
  import vram_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK21M,
  input  logic        RESET,
  input  logic        cpu_wr_stb,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rd_stb,
  input  logic        cpu_addr_stb,
  input  logic [18:0] cpu_addr,
  input  logic        cpu_addr_read,
  input  logic        VDPVRAMWRACK,
  input  logic        VDPVRAMRDACK,
  input  logic        VDPVRAMADDRSETACK,
  input  logic        vram_rd_valid,
  input  logic [7:0]  vram_rd_data,
  output logic        VDPVRAMWRREQ,
  output logic        VDPVRAMRDREQ,
  output logic        VDPVRAMADDRSETREQ,
  output logic [7:0]  VDPVRAMACCESSDATA,
  output logic [18:0] VDPVRAMACCESSADDRTMP,
  output logic [7:0]  cpu_rd_data,
  output logic        queue_full,
  output logic        busy,
  output logic        overflow
);

  state_t      state_q;
  logic        wrreq_q, rdreq_q, addrsetreq_q;
  logic [7:0]  data_q;
  logic [18:0] addrtmp_q;
  logic [7:0]  rd_data_q;
  logic        overflow_q, overflow_d;

  vram_entry_t push_entry, head;
  logic        push_valid, pop, fifo_full, fifo_empty;
  logic        drop_coincident, drop_full;

  // Priority addr > wr > rd; every lower-priority strobe in the same cycle is lost.
  always_comb begin
    push_entry      = make_entry(KIND_WR, '0);
    push_valid      = cpu_addr_stb || cpu_wr_stb || cpu_rd_stb;
    drop_coincident = (cpu_addr_stb && cpu_wr_stb) || ((cpu_addr_stb || cpu_wr_stb) && cpu_rd_stb);
    if (cpu_addr_stb) begin
      push_entry = make_entry(cpu_addr_read ? KIND_ADDR_R : KIND_ADDR_W, cpu_addr);
    end else if (cpu_wr_stb) begin
      push_entry = make_entry(KIND_WR, {11'd0, cpu_wr_data});
    end else if (cpu_rd_stb) begin
      push_entry = make_entry(KIND_RD, '0);
    end
  end

  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign drop_full  = push_valid && fifo_full && !pop;
  assign overflow_d = overflow_q || drop_coincident || drop_full;

  vram_port_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (CLK21M),
    .rst_i       (RESET),
    .push_i      (push_valid),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      wrreq_q      <= 1'b0;
      rdreq_q      <= 1'b0;
      addrsetreq_q <= 1'b0;
      data_q       <= '0;
      addrtmp_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            case (head.kind)
              KIND_WR: begin
                data_q  <= head.payload[7:0];
                wrreq_q <= ~wrreq_q;
                state_q <= ST_WAIT_WR;
              end
              KIND_ADDR_W: begin
                addrtmp_q    <= head.payload;
                addrsetreq_q <= ~addrsetreq_q;
                state_q      <= ST_WAIT_ADDR;
              end
              KIND_ADDR_R: begin
                // The arbiter performs the address set inside its read slot,
                // so completion is tracked on the read toggle pair alone.
                addrtmp_q    <= head.payload;
                addrsetreq_q <= ~addrsetreq_q;
                rdreq_q      <= ~rdreq_q;
                state_q      <= ST_WAIT_RD;
              end
              KIND_RD: begin
                rdreq_q <= ~rdreq_q;
                state_q <= ST_WAIT_RD;
              end
            endcase
          end
        end
        ST_WAIT_WR:   if (wrreq_q == VDPVRAMWRACK) state_q <= ST_IDLE;
        ST_WAIT_ADDR: if (addrsetreq_q == VDPVRAMADDRSETACK) state_q <= ST_IDLE;
        ST_WAIT_RD:   if (rdreq_q == VDPVRAMRDACK) state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (vram_rd_valid) rd_data_q <= vram_rd_data;
      overflow_q <= overflow_d;
    end
  end

  assign VDPVRAMWRREQ         = wrreq_q;
  assign VDPVRAMRDREQ         = rdreq_q;
  assign VDPVRAMADDRSETREQ    = addrsetreq_q;
  assign VDPVRAMACCESSDATA    = data_q;
  assign VDPVRAMACCESSADDRTMP = addrtmp_q;
  assign cpu_rd_data          = rd_data_q;
  assign queue_full           = fifo_full;
  assign busy                 = !fifo_empty || (state_q != ST_IDLE);
  assign overflow             = overflow_q;

endmodule

// File: tb/tb_vram_cpu_port_queue.sv
// tb/tb_vram_cpu_port_queue.sv - self-checking bench for vram_cpu_port_queue
module tb_vram_cpu_port_queue;

  logic        CLK21M = 1'b0;
  logic        RESET  = 1'b1;
  logic        cpu_wr_stb = 1'b0;
  logic [7:0]  cpu_wr_data = '0;
  logic        cpu_rd_stb = 1'b0;
  logic        cpu_addr_stb = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic        cpu_addr_read = 1'b0;
  logic [2:0]  acks = '0;  // {WR, ADDRSET, RD}
  logic        vram_rd_valid = 1'b0;
  logic [7:0]  vram_rd_data = '0;
  logic        VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ;
  logic [7:0]  VDPVRAMACCESSDATA;
  logic [18:0] VDPVRAMACCESSADDRTMP;
  logic [7:0]  cpu_rd_data;
  logic        queue_full, busy, overflow;

  int checks = 0;
  int errors = 0;
  logic        auto_ack = 1'b0;
  logic        mon_en = 1'b0;
  logic [21:0] exp_q[$];  // {toggle mask {WR,ADDRSET,RD}, payload}
  logic [2:0]  prev_req = '0;
  logic [2:0]  prev_ack = '0;

  vram_cpu_port_queue #(.FIFO_DEPTH(4)) dut (
    .CLK21M               (CLK21M),
    .RESET                (RESET),
    .cpu_wr_stb           (cpu_wr_stb),
    .cpu_wr_data          (cpu_wr_data),
    .cpu_rd_stb           (cpu_rd_stb),
    .cpu_addr_stb         (cpu_addr_stb),
    .cpu_addr             (cpu_addr),
    .cpu_addr_read        (cpu_addr_read),
    .VDPVRAMWRACK         (acks[2]),
    .VDPVRAMRDACK         (acks[0]),
    .VDPVRAMADDRSETACK    (acks[1]),
    .vram_rd_valid        (vram_rd_valid),
    .vram_rd_data         (vram_rd_data),
    .VDPVRAMWRREQ         (VDPVRAMWRREQ),
    .VDPVRAMRDREQ         (VDPVRAMRDREQ),
    .VDPVRAMADDRSETREQ    (VDPVRAMADDRSETREQ),
    .VDPVRAMACCESSDATA    (VDPVRAMACCESSDATA),
    .VDPVRAMACCESSADDRTMP (VDPVRAMACCESSADDRTMP),
    .cpu_rd_data          (cpu_rd_data),
    .queue_full           (queue_full),
    .busy                 (busy),
    .overflow             (overflow)
  );

  always #5 CLK21M = ~CLK21M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbiter model: acknowledges every outstanding request a few ns after the edge.
  always @(posedge CLK21M) begin
    #3;
    if (RESET) acks = '0;
    else if (auto_ack) acks = {VDPVRAMWRREQ, VDPVRAMADDRSETREQ, VDPVRAMRDREQ};
  end

  // Issue monitor: every toggle edge is matched against the scoreboard.
  always @(negedge CLK21M) begin
    logic [2:0]  cur, mask;
    logic [18:0] val;
    logic [21:0] e;
    cur = {VDPVRAMWRREQ, VDPVRAMADDRSETREQ, VDPVRAMRDREQ};
    if (mon_en && !RESET && cur !== prev_req) begin
      mask = cur ^ prev_req;
      val  = mask[2] ? {11'd0, VDPVRAMACCESSDATA} : (mask[1] ? VDPVRAMACCESSADDRTMP : 19'd0);
      chk("one_outstanding", {29'd0, prev_req}, {29'd0, prev_ack});
      chk("expected_issue", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_order", {10'd0, mask, val}, {10'd0, e});
      end
    end
    prev_req = cur;
    prev_ack = acks;
  end

  task automatic cyc(input logic w, input logic [7:0] wd, input logic a,
                     input logic [18:0] ad, input logic ar, input logic r);
    cpu_wr_stb = w; cpu_wr_data = wd;
    cpu_addr_stb = a; cpu_addr = ad; cpu_addr_read = ar;
    cpu_rd_stb = r;
    @(posedge CLK21M); #1;
    cpu_wr_stb = 1'b0; cpu_addr_stb = 1'b0; cpu_rd_stb = 1'b0; cpu_addr_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK21M); #1; end
  endtask

  task automatic rd_byte(input logic [7:0] d);
    vram_rd_valid = 1'b1; vram_rd_data = d;
    @(posedge CLK21M); #1;
    vram_rd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge CLK21M); #1; n++;
    end
    chk(tag, {30'd0, exp_q.size() == 0, busy}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge CLK21M);
    #1;
    chk("reset_reqs", {29'd0, VDPVRAMWRREQ, VDPVRAMADDRSETREQ, VDPVRAMRDREQ}, 32'd0);
    chk("reset_data", {VDPVRAMACCESSDATA, cpu_rd_data}, 32'd0);
    chk("reset_addrtmp", {13'd0, VDPVRAMACCESSADDRTMP}, 32'd0);
    chk("reset_flags", {29'd0, queue_full, busy, overflow}, 32'd0);
    RESET = 1'b0;
    idle(1);
    mon_en = 1'b1;
    auto_ack = 1'b1;

    // Read-mode address set: both toggles one clock after the sampling edge.
    exp_q.push_back({3'b011, 19'h12345});
    cyc(0, 8'h00, 1, 19'h12345, 1, 0);
    chk("addr_r_latency0", {30'd0, VDPVRAMADDRSETREQ, VDPVRAMRDREQ}, 32'd0);
    idle(1);
    chk("addr_r_toggles", {30'd0, VDPVRAMADDRSETREQ, VDPVRAMRDREQ}, 32'd3);
    chk("addr_r_addrtmp", {13'd0, VDPVRAMACCESSADDRTMP}, 32'h12345);
    rd_byte(8'hA5);
    chk("rd_data_a5", {24'd0, cpu_rd_data}, 32'hA5);
    drain("addr_r_drain");

    // Stalled arbiter: one write issued, four queued, sixth dropped.
    auto_ack = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back({3'b100, 11'd0, 8'(i)});
      cyc(1, 8'(i), 0, 19'd0, 0, 0);
    end
    chk("stall_full", {31'd0, queue_full}, 32'd1);
    chk("stall_no_ovf", {31'd0, overflow}, 32'd0);
    chk("stall_queued", exp_q.size(), 32'd4);
    cyc(1, 8'h06, 0, 19'd0, 0, 0);
    chk("stall_ovf", {31'd0, overflow}, 32'd1);
    auto_ack = 1'b1;
    drain("stall_drain");
    chk("stall_not_full", {31'd0, queue_full}, 32'd0);

    // Mixed ordering: WR, ADDR_W, WR.
    exp_q.push_back({3'b100, 11'd0, 8'h11});
    exp_q.push_back({3'b010, 19'h00100});
    exp_q.push_back({3'b100, 11'd0, 8'h22});
    cyc(1, 8'h11, 0, 19'd0, 0, 0);
    cyc(0, 8'h00, 1, 19'h00100, 0, 0);
    cyc(1, 8'h22, 0, 19'd0, 0, 0);
    drain("mixed_drain");

    // Read-ahead request: RD toggle only.
    exp_q.push_back({3'b001, 19'd0});
    cyc(0, 8'h00, 0, 19'd0, 0, 1);
    drain("rd_drain");
    rd_byte(8'h3C);
    chk("rd_data_3c", {24'd0, cpu_rd_data}, 32'h3C);

    // Reset with a write outstanding and three entries queued.
    auto_ack = 1'b0;
    exp_q.push_back({3'b100, 11'd0, 8'hA1});
    cyc(1, 8'hA1, 0, 19'd0, 0, 0);
    cyc(1, 8'hA2, 0, 19'd0, 0, 0);
    cyc(1, 8'hA3, 0, 19'd0, 0, 0);
    cyc(1, 8'hA4, 0, 19'd0, 0, 0);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    chk("pre_reset_sb", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    #1 RESET = 1'b1;
    #1;
    chk("async_reset_reqs", {29'd0, VDPVRAMWRREQ, VDPVRAMADDRSETREQ, VDPVRAMRDREQ}, 32'd0);
    chk("async_reset_data", {VDPVRAMACCESSDATA, cpu_rd_data}, 32'd0);
    chk("async_reset_addrtmp", {13'd0, VDPVRAMACCESSADDRTMP}, 32'd0);
    chk("async_reset_flags", {29'd0, queue_full, busy, overflow}, 32'd0);
    repeat (2) @(posedge CLK21M);
    #1 RESET = 1'b0;
    idle(1);
    mon_en = 1'b1;
    auto_ack = 1'b1;
    idle(10);
    chk("post_reset_reqs", {29'd0, VDPVRAMWRREQ, VDPVRAMADDRSETREQ, VDPVRAMRDREQ}, 32'd0);
    chk("post_reset_idle", {30'd0, busy, overflow}, 32'd0);

    // Coincident addr and wr strobes: address set wins, write dropped.
    exp_q.push_back({3'b010, 19'h00777});
    cyc(1, 8'h99, 1, 19'h00777, 0, 0);
    chk("coincident_ovf", {31'd0, overflow}, 32'd1);
    drain("coincident_drain");
    idle(5);
    chk("final_sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_cpu_port_queue.md
# vram_cpu_port_queue

Ordering queue and request sequencer between the CPU I/O port decoder and the VRAM access arbiter. It buffers CPU VRAM writes, address sets and read-ahead requests in a small FIFO, so that CPU bursts are not lost while display or sprite fetches hold the VRAM slots. Entries are issued strictly in arrival order as toggle-handshake requests (WRREQ/RDREQ/ADDRSETREQ) to the arbiter. The block also holds the read-ahead byte that the CPU reads from port #0.

## Interface
- FIFO_DEPTH, 4, queue entries; power of two, 2..16
- CLK21M  in  1  system clock
- RESET  in  1  reset, asynchronous, active-high
- cpu_wr_stb  in  1  one-cycle pulse: CPU writes cpu_wr_data to VRAM port
- cpu_wr_data  in  8  write byte
- cpu_rd_stb  in  1  one-cycle pulse: CPU consumed cpu_rd_data; schedule next read-ahead
- cpu_addr_stb  in  1  one-cycle pulse: CPU completed an address set
- cpu_addr  in  19  new VRAM address
- cpu_addr_read  in  1  address set was in read mode (prefetch required)
- VDPVRAMWRACK / VDPVRAMRDACK / VDPVRAMADDRSETACK  in  1 each  arbiter ack toggles
- vram_rd_valid  in  1  one-cycle pulse: read byte available
- vram_rd_data  in  8  read byte
- VDPVRAMWRREQ / VDPVRAMRDREQ / VDPVRAMADDRSETREQ  out  1 each  request toggles
- VDPVRAMACCESSDATA  out  8  write byte for the current WR entry
- VDPVRAMACCESSADDRTMP  out  19  address for the current address-set entry
- cpu_rd_data  out  8  read-ahead byte
- queue_full  out  1  FIFO holds FIFO_DEPTH entries
- busy  out  1  FIFO non-empty or a request is outstanding
- overflow  out  1  sticky; a strobe was dropped

## Operation
- Entry = {kind[1:0], payload[18:0]}. Kinds: WR (payload[7:0] = data), ADDR_W, ADDR_R (payload = address), RD (payload unused).
- Push: cpu_wr_stb → WR; cpu_addr_stb → ADDR_R if cpu_addr_read, else ADDR_W; cpu_rd_stb → RD.
- Coincident strobes: only the highest-priority strobe is pushed (priority addr > wr > rd). Each lower-priority strobe is dropped and sets overflow.
- Strobe while queue_full, with no pop in the same cycle: the strobe is dropped and sets overflow. Push and pop in the same cycle when full are legal; occupancy is unchanged.
- FSM states: IDLE, WAIT_WR, WAIT_ADDR, WAIT_RD.
- In IDLE with the FIFO non-empty, the head entry is popped and its request issued:
  - WR: drive VDPVRAMACCESSDATA = payload[7:0], toggle WRREQ → WAIT_WR.
  - ADDR_W: drive ADDRTMP = payload, toggle ADDRSETREQ → WAIT_ADDR.
  - ADDR_R: drive ADDRTMP = payload, toggle ADDRSETREQ and RDREQ in the same edge → WAIT_RD. The arbiter consumes the address set inside its CPU-read slot.
  - RD: toggle RDREQ → WAIT_RD.
- Each WAIT_* state returns to IDLE when its request toggle equals its ack toggle. WAIT_RD compares only RDREQ/RDACK.
- At most one request is outstanding at a time. DATA and ADDRTMP hold their values until the next issue.
- vram_rd_valid loads cpu_rd_data in any state. The latest pulse wins.
- overflow clears only on RESET.

## Timing
- Reset values: all REQ toggles 0, VDPVRAMACCESSDATA 0, ADDRTMP 0, cpu_rd_data 0, queue_full 0, busy 0, overflow 0, FSM IDLE, FIFO empty.
- Strobe sampled at edge N; the entry is visible at N+1. The pop and the request toggle are registered at edge N+1, so an empty, idle block has a strobe-to-toggle latency of 1 clock.
- Ack equality seen at edge M → IDLE at M; the next pop happens at M+1. Back-to-back WR entries therefore issue at most every 2 clocks plus the arbiter latency.
- queue_full and busy are registered and reflect state after the current edge.
- Reset mid-operation returns everything to reset values. The arbiter shares RESET, so the toggle pairs realign at 0 and no stale request remains.

## Structure
- Package vram_port_pkg holds: entry_kind_t enum (WR, ADDR_W, ADDR_R, RD), vram_entry_t packed struct {kind, payload}, and the FSM state enum.
- Sub-module vram_port_fifo: synchronous FIFO of vram_entry_t, parameter FIFO_DEPTH, with push/pop/full/empty and simultaneous push+pop support.
- The FSM, push priority logic and read-ahead register stay in the top module.

## Test plan
- Reset, then cpu_addr_stb with addr=0x12345 and read=1 → ADDRSETREQ and RDREQ both 1 one clock later, ADDRTMP=0x12345. Return RDACK=1, then pulse vram_rd_valid with 0xA5 → cpu_rd_data=0xA5, busy=0.
- Arbiter stalls (acks held) while 5 writes 0x01..0x05 arrive with FIFO_DEPTH=4 → 1 issued and 4 queued, queue_full=1, no overflow. A 6th write → overflow=1. Releasing the acks → DATA sequence 01,02,03,04,05.
- WR 0x11, then ADDR_W 0x00100, then WR 0x22 → WRREQ, ADDRSETREQ, WRREQ toggles occur in that order, and ADDRSETREQ toggles only after WRACK matches.
- cpu_rd_stb → RDREQ toggles, no ADDRSETREQ. Pulse vram_rd_valid 0x3C → cpu_rd_data=0x3C.
- Same-cycle cpu_addr_stb and cpu_wr_stb → only ADDR entry queued, overflow=1.
- RESET asserted with WAIT_WR outstanding and 3 entries queued → all outputs return to 0 asynchronously. After release the FIFO is empty and no toggle occurs.
